// File: rtl/pipeline_decode.sv
// RV32I decode stage: IF/ID latch, register file, immediate/control decode, load-use stall, ID/EX register.
// Optional macro PIPELINE_DECODE_WB_BYPASS_EN forwards a same-cycle writeback into the captured operands.
module pipeline_decode #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [31:0]     instruction_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pcsrc_i,
  input  logic            flush_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pcplus4_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic            funct7b5_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            mem_to_reg_o,
  output logic            alu_src_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            jalr_o,
  output logic            lui_o,
  output logic            auipc_o,
  output logic            illegal_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [31:0]     ifid_instr;
  logic [XLEN-1:0] ifid_pc;
  logic [XLEN-1:0] ifid_pcplus4;
  logic            ifid_valid;
  logic [XLEN-1:0] regs [32];

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic hit1, hit2;

  logic dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg, dec_alu_src;
  logic dec_branch, dec_jump, dec_jalr, dec_lui, dec_auipc, dec_illegal;
  logic uses_rs1, uses_rs2;
  logic [XLEN-1:0] dec_imm;

  assign opcode = ifid_instr[6:0];
  assign rd     = ifid_instr[11:7];
  assign rs1    = ifid_instr[19:15];
  assign rs2    = ifid_instr[24:20];

  assign imm_i = {{(XLEN-12){ifid_instr[31]}}, ifid_instr[31:20]};
  assign imm_s = {{(XLEN-12){ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
  assign imm_b = {{(XLEN-12){ifid_instr[31]}}, ifid_instr[7], ifid_instr[30:25], ifid_instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){ifid_instr[31]}}, ifid_instr[31:12], 12'h000};
  assign imm_j = {{(XLEN-20){ifid_instr[31]}}, ifid_instr[19:12], ifid_instr[20], ifid_instr[30:21], 1'b0};

`ifdef PIPELINE_DECODE_WB_BYPASS_EN
  assign hit1 = wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs1);
  assign hit2 = wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs2);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  assign rs1_val = (rs1 == 5'd0) ? '0 : (hit1 ? wb_data_i : regs[rs1]);
  assign rs2_val = (rs2 == 5'd0) ? '0 : (hit2 ? wb_data_i : regs[rs2]);

  // Opcode decode: control bits, immediate format and source-register usage
  always_comb begin
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src    = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_jalr       = 1'b0;
    dec_lui        = 1'b0;
    dec_auipc      = 1'b0;
    dec_illegal    = 1'b0;
    uses_rs1       = 1'b0;
    uses_rs2       = 1'b0;
    dec_imm        = '0;
    case (opcode)
      OP_LUI:    begin dec_reg_write = 1'b1; dec_lui = 1'b1; dec_alu_src = 1'b1; dec_imm = imm_u; end
      OP_AUIPC:  begin dec_reg_write = 1'b1; dec_auipc = 1'b1; dec_alu_src = 1'b1; dec_imm = imm_u; end
      OP_JAL:    begin dec_reg_write = 1'b1; dec_jump = 1'b1; dec_imm = imm_j; end
      OP_JALR:   begin
        dec_reg_write = 1'b1; dec_jump = 1'b1; dec_jalr = 1'b1; dec_alu_src = 1'b1;
        dec_imm = imm_i; uses_rs1 = 1'b1;
      end
      OP_BRANCH: begin dec_branch = 1'b1; dec_imm = imm_b; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_LOAD:   begin
        dec_reg_write = 1'b1; dec_mem_read = 1'b1; dec_mem_to_reg = 1'b1; dec_alu_src = 1'b1;
        dec_imm = imm_i; uses_rs1 = 1'b1;
      end
      OP_STORE:  begin
        dec_mem_write = 1'b1; dec_alu_src = 1'b1; dec_imm = imm_s; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_IMM:    begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_imm = imm_i; uses_rs1 = 1'b1; end
      OP_OP:     begin dec_reg_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      default:   dec_illegal = 1'b1;
    endcase
  end

  // The bubble clears mem_read_o, so a load-use stall can never last more than one cycle
  assign stall_o = !reset_i && ifid_valid && !flush_i && valid_o && mem_read_o && (rd_o != 5'd0) &&
                   ((uses_rs1 && (rs1 == rd_o)) || (uses_rs2 && (rs2 == rd_o)));

  // IF/ID register: flush beats stall beats capture
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ifid_instr   <= NOP_INSTR;
      ifid_valid   <= 1'b0;
      ifid_pc      <= '0;
      ifid_pcplus4 <= '0;
    end else if (flush_i) begin
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (!stall_o) begin
      ifid_instr   <= instruction_i;
      ifid_pc      <= pc_i;
      ifid_pcplus4 <= pcsrc_i;
      ifid_valid   <= 1'b1;
    end
  end

  // Register file write port; x0 is never written and reads are masked to zero
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en_i && (wb_rd_i != 5'd0)) begin
      regs[wb_rd_i] <= wb_data_i;
    end
  end

  // ID/EX register: reset and bubbles both drive every field to zero
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i || stall_o) begin
      valid_o <= 1'b0; pc_o <= '0; pcplus4_o <= '0; rs1_data_o <= '0; rs2_data_o <= '0; imm_o <= '0;
      rs1_o <= 5'd0; rs2_o <= 5'd0; rd_o <= 5'd0; funct3_o <= 3'd0; funct7b5_o <= 1'b0;
      reg_write_o <= 1'b0; mem_read_o <= 1'b0; mem_write_o <= 1'b0; mem_to_reg_o <= 1'b0;
      alu_src_o <= 1'b0; branch_o <= 1'b0; jump_o <= 1'b0; jalr_o <= 1'b0; lui_o <= 1'b0;
      auipc_o <= 1'b0; illegal_o <= 1'b0;
    end else begin
      valid_o      <= ifid_valid;
      pc_o         <= ifid_pc;
      pcplus4_o    <= ifid_pcplus4;
      rs1_data_o   <= rs1_val;
      rs2_data_o   <= rs2_val;
      imm_o        <= dec_imm;
      rs1_o        <= rs1;
      rs2_o        <= rs2;
      rd_o         <= rd;
      funct3_o     <= ifid_instr[14:12];
      funct7b5_o   <= ifid_instr[30];
      reg_write_o  <= ifid_valid && dec_reg_write && (rd != 5'd0);
      mem_read_o   <= ifid_valid && dec_mem_read;
      mem_write_o  <= ifid_valid && dec_mem_write;
      mem_to_reg_o <= ifid_valid && dec_mem_to_reg;
      alu_src_o    <= ifid_valid && dec_alu_src;
      branch_o     <= ifid_valid && dec_branch;
      jump_o       <= ifid_valid && dec_jump;
      jalr_o       <= ifid_valid && dec_jalr;
      lui_o        <= ifid_valid && dec_lui;
      auipc_o      <= ifid_valid && dec_auipc;
      illegal_o    <= ifid_valid && dec_illegal;
    end
  end

endmodule

// File: tb/tb_pipeline_decode.sv
// Bench for pipeline_decode: directed scenarios plus random stimulus against a spec-level model.
module tb_pipeline_decode;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [10:0] RW = 11'h400, MR = 11'h200, MW = 11'h100, M2R = 11'h080, AS = 11'h040;
  localparam logic [10:0] BR = 11'h020, JP = 11'h010, JR = 11'h008, LU = 11'h004, AU = 11'h002, IL = 11'h001;

  typedef struct packed {
    logic        valid;
    logic [10:0] ctl;
    logic [31:0] pc, pc4, r1d, r2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
  } ex_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1, flush_i = 1'b0, wb_en_i = 1'b0;
  logic [31:0] instruction_i = NOP, pc_i = 32'd0, pcsrc_i = 32'd4, wb_data_i = 32'd0;
  logic [4:0] wb_rd_i = 5'd0;
  logic stall_o, valid_o, funct7b5_o;
  logic [31:0] pc_o, pcplus4_o, rs1_data_o, rs2_data_o, imm_o;
  logic [4:0] rs1_o, rs2_o, rd_o;
  logic [2:0] funct3_o;
  logic reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, alu_src_o;
  logic branch_o, jump_o, jalr_o, lui_o, auipc_o, illegal_o;

  pipeline_decode dut (
    .clk_i(clk), .reset_i(reset_i), .instruction_i(instruction_i), .pc_i(pc_i), .pcsrc_i(pcsrc_i),
    .flush_i(flush_i), .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .stall_o(stall_o), .valid_o(valid_o), .pc_o(pc_o), .pcplus4_o(pcplus4_o),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .funct3_o(funct3_o), .funct7b5_o(funct7b5_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_to_reg_o(mem_to_reg_o), .alu_src_o(alu_src_o), .branch_o(branch_o), .jump_o(jump_o),
    .jalr_o(jalr_o), .lui_o(lui_o), .auipc_o(auipc_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [31:0] pc_cnt = 32'd0;

  // Model state: IF/ID contents, architectural registers, expected ID/EX contents
  logic [31:0] m_instr = NOP, m_pc = 32'd0, m_pc4 = 32'd0;
  logic        m_ifv = 1'b0;
  logic [31:0] m_regs [32];
  ex_t         m_ex = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [10:0] ctl_of(input logic [6:0] op);
    case (op)
      7'b0110111: return RW | LU | AS;
      7'b0010111: return RW | AU | AS;
      7'b1101111: return RW | JP;
      7'b1100111: return RW | JP | JR | AS;
      7'b1100011: return BR;
      7'b0000011: return RW | MR | M2R | AS;
      7'b0100011: return MW | AS;
      7'b0010011: return RW | AS;
      7'b0110011: return RW;
      default:    return IL;
    endcase
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] i);
    logic signed [31:0] s;
    s = $signed(i);
    case (i[6:0])
      7'b1100111, 7'b0000011, 7'b0010011: return 32'(s >>> 20);
      7'b0100011: return {32'(s >>> 25)} << 5 | {27'd0, i[11:7]};
      7'b1100011: return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      7'b0110111, 7'b0010111: return i & 32'hFFFF_F000;
      7'b1101111: return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {7'b1100011, 7'b0100011, 7'b0110011};
  endfunction

  function automatic logic model_stall();
    logic [4:0] r1, r2;
    r1 = m_instr[19:15];
    r2 = m_instr[24:20];
    if (reset_i || flush_i || !m_ifv || !m_ex.valid || !m_ex.ctl[9] || m_ex.rd == 5'd0) return 1'b0;
    return (reads_rs1(m_instr[6:0]) && r1 == m_ex.rd) || (reads_rs2(m_instr[6:0]) && r2 == m_ex.rd);
  endfunction

  function automatic logic [31:0] read_reg(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef PIPELINE_DECODE_WB_BYPASS_EN
    if (wb_en_i && wb_rd_i == idx) return wb_data_i;
`endif
    return m_regs[idx];
  endfunction

  // Advance the model across one rising edge using the inputs currently applied
  task automatic model_edge();
    ex_t n;
    logic st;
    n = '0;
    if (reset_i) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_instr = NOP; m_ifv = 1'b0; m_pc = 32'd0; m_pc4 = 32'd0; m_ex = '0;
      return;
    end
    st = model_stall();
    if (!flush_i && !st) begin
      n.valid = m_ifv;
      n.ctl   = m_ifv ? ctl_of(m_instr[6:0]) : 11'd0;
      if (m_instr[11:7] == 5'd0) n.ctl = n.ctl & ~RW;
      n.pc = m_pc; n.pc4 = m_pc4; n.imm = imm_of(m_instr);
      n.rs1 = m_instr[19:15]; n.rs2 = m_instr[24:20]; n.rd = m_instr[11:7];
      n.f3 = m_instr[14:12]; n.f7 = m_instr[30];
      n.r1d = read_reg(n.rs1); n.r2d = read_reg(n.rs2);
    end
    if (wb_en_i && wb_rd_i != 5'd0) m_regs[wb_rd_i] = wb_data_i;
    if (flush_i) begin
      m_ifv = 1'b0; m_instr = NOP;
    end else if (!st) begin
      m_ifv = 1'b1; m_instr = instruction_i; m_pc = pc_i; m_pc4 = pcsrc_i;
    end
    m_ex = n;
  endtask

  task automatic compare_all();
    logic [10:0] ctl;
    ctl = {reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, alu_src_o, branch_o,
           jump_o, jalr_o, lui_o, auipc_o, illegal_o};
    chk("valid", {31'd0, valid_o}, {31'd0, m_ex.valid});
    chk("controls", {21'd0, ctl}, {21'd0, m_ex.ctl});
    if (m_ex.valid) begin
      chk("pc", pc_o, m_ex.pc);
      chk("pcplus4", pcplus4_o, m_ex.pc4);
      chk("rs1_data", rs1_data_o, m_ex.r1d);
      chk("rs2_data", rs2_data_o, m_ex.r2d);
      chk("imm", imm_o, m_ex.imm);
      chk("fields", {15'd0, rs1_o, rs2_o, rd_o, funct3_o, funct7b5_o},
          {15'd0, m_ex.rs1, m_ex.rs2, m_ex.rd, m_ex.f3, m_ex.f7});
    end
  endtask

  // One clock: stall check before the edge, model update, output comparison after it
  task automatic cycle(input int exp_stall);
    #1;
    chk("stall", {31'd0, stall_o}, {31'd0, model_stall()});
    if (exp_stall >= 0) chk("stall_lit", {31'd0, stall_o}, 32'(exp_stall));
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [31:0] ins, input logic fl, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic rs, input int es);
    instruction_i = ins; pc_i = pc_cnt; pcsrc_i = pc_cnt + 32'd4; pc_cnt = pc_cnt + 32'd4;
    flush_i = fl; wb_en_i = we; wb_rd_i = wr; wb_data_i = wd; reset_i = rs;
    cycle(es);
  endtask

  task automatic feed(input logic [31:0] ins);
    drive(ins, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, -1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0000011};
    r = $urandom;
    r[6:0]   = ($urandom_range(0, 11) < 10) ? ops[$urandom_range(0, 9)] : 7'($urandom);
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  initial begin
    logic [31:0] exp_x7;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    drive(NOP, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 0);
    drive(NOP, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 0);
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    chk("reset_pc", pc_o, 32'd0);
    chk("reset_imm", imm_o, 32'd0);

    pc_cnt = 32'd0;
    feed(32'h0050_0093);
    feed(NOP);
    chk("addi_valid", {31'd0, valid_o}, 32'd1);
    chk("addi_rd", {27'd0, rd_o}, 32'd1);
    chk("addi_imm", imm_o, 32'd5);
    chk("addi_rw_as", {30'd0, reg_write_o, alu_src_o}, 32'd3);
    chk("addi_pc4", pcplus4_o, 32'd4);

    drive(NOP, 1'b0, 1'b1, 5'd2, 32'hDEAD_BEEF, 1'b0, -1);
    drive(NOP, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, -1);
    feed(32'h0001_01B3);
    feed(32'h0000_01B3);
    chk("add_rs1", rs1_data_o, 32'hDEAD_BEEF);
    chk("add_rs2", rs2_data_o, 32'd0);
    feed(NOP);
    chk("x0_read", rs1_data_o, 32'd0);

    feed(32'h0000_A283);
    feed(32'h0052_8333);
    drive(32'h0052_8333, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1);
    chk("bubble_valid", {31'd0, valid_o}, 32'd0);
    chk("bubble_mr", {30'd0, mem_read_o, reg_write_o}, 32'd0);
    drive(NOP, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 0);
    chk("use_regs", {22'd0, rs1_o, rs2_o}, {22'd0, 5'd5, 5'd5});
    chk("use_valid", {31'd0, valid_o}, 32'd1);

    feed(32'hFE20_8CE3);
    feed(NOP);
    chk("beq_imm", imm_o, 32'hFFFF_FFF8);
    chk("beq_br_rw", {30'd0, branch_o, reg_write_o}, 32'd2);
    drive(NOP, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 0);
    chk("flush_valid", {31'd0, valid_o}, 32'd0);
    feed(32'h0000_A283);
    feed(32'h0052_8333);
    drive(NOP, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 0);
    chk("flush_stall_valid", {31'd0, valid_o}, 32'd0);

    feed(32'h0000_007F);
    feed(NOP);
    chk("illegal", {31'd0, illegal_o}, 32'd1);
    chk("illegal_ctl", {29'd0, reg_write_o, mem_read_o, mem_write_o}, 32'd0);
    feed(32'h0000_A283);
    feed(32'h0052_8333);
    drive(NOP, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 0);
    chk("rst_stall_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_stall_mr", {31'd0, mem_read_o}, 32'd0);
    chk("rst_stall_pc", pc_o, 32'd0);
    feed(NOP);

    drive(NOP, 1'b0, 1'b1, 5'd7, 32'h0000_5555, 1'b0, -1);
    feed(32'h0003_8433);
    drive(NOP, 1'b0, 1'b1, 5'd7, 32'h0000_1234, 1'b0, -1);
`ifdef PIPELINE_DECODE_WB_BYPASS_EN
    exp_x7 = 32'h0000_1234;
`else
    exp_x7 = 32'h0000_5555;
`endif
    chk("wb_same_cycle", rs1_data_o, exp_x7);
    feed(32'h0003_8433);
    feed(NOP);
    chk("wb_next_cycle", rs1_data_o, 32'h0000_1234);

    for (int n = 0; n < 600; n++) begin
      drive(rand_instr(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 59) == 0), -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
